// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin arbiter lending one interval counter to NUM_REQ requesters.
module counter_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] len,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         count
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               r_state, w_state_n;
  logic [IW-1:0]        r_idx, w_idx_n, r_last, w_last_n, w_win, w_j;
  logic [CNT_W-1:0]     r_len, w_len_n, r_count, w_cnt_n;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt_n, r_done, w_done_n;
  assign gnt   = r_gnt;
  assign done  = r_done;
  assign count = r_count;
  assign busy  = r_state != IDLE;
  // Walk from the farthest candidate to the nearest so the nearest set bit after r_last wins.
  always_comb begin
    w_win = r_last;
    w_j   = r_last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_j = IW'((int'(r_last) + k) % NUM_REQ);
      if (req[w_j]) w_win = w_j;
    end
  end
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_len_n   = r_len;
    w_last_n  = r_last;
    w_gnt_n   = r_gnt;
    w_done_n  = '0;
    w_cnt_n   = r_count;
    case (r_state)
      IDLE: begin
        w_gnt_n = '0;
        w_cnt_n = '0;
        if (|req) begin
          w_state_n = RUN;
          w_idx_n   = w_win;
          w_len_n   = len[w_win*CNT_W +: CNT_W];
          w_gnt_n   = NUM_REQ'(1) << w_win;
        end
      end
      RUN: begin
        if (!req[r_idx]) begin
          w_state_n = IDLE;
          w_gnt_n   = '0;
          w_cnt_n   = '0;
          w_last_n  = r_idx;
        end else if (r_count == r_len) begin
          w_state_n = DONE;
          w_done_n  = r_gnt;
        end else w_cnt_n = r_count + CNT_W'(1);
      end
      default: begin
        w_state_n = IDLE;
        w_gnt_n   = '0;
        w_cnt_n   = '0;
        w_last_n  = r_idx;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_last  <= IW'(NUM_REQ - 1);
      r_gnt   <= '0;
      r_done  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_len   <= w_len_n;
      r_last  <= w_last_n;
      r_gnt   <= w_gnt_n;
      r_done  <= w_done_n;
      r_count <= w_cnt_n;
    end
  end
endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: directed and random stimulus against an interval-age reference model.
module tb_counter_scheduler;
  logic        clk = 0;
  logic        rst = 1;
  logic [3:0]  req = '0;
  logic [31:0] len = '0;
  logic [3:0]  gnt, done;
  logic        busy;
  logic [7:0]  count;
  int checks = 0, errors = 0;
  int m_owner = -1, m_last = 3, m_age = 0, m_len = 0;
  logic seen_done;

  counter_scheduler #(.NUM_REQ(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len),
    .gnt(gnt), .done(done), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // An interval is tracked by its age since the grant: ages 0..len count, age len+1 signals done.
  task automatic check_all(input string tag);
    logic [3:0] eg;
    eg = m_owner >= 0 ? 4'(1 << m_owner) : 4'd0;
    check({tag, ".gnt"},   32'(gnt),   32'(eg));
    check({tag, ".done"},  32'(done),  (m_owner >= 0 && m_age == m_len + 1) ? 32'(eg) : 32'd0);
    check({tag, ".busy"},  32'(busy),  32'(m_owner >= 0));
    check({tag, ".count"}, 32'(count), m_owner >= 0 ? 32'(m_age < m_len ? m_age : m_len) : 32'd0);
  endtask

  task automatic model_tick();
    if (m_owner < 0) begin
      if (req != 0)
        for (int k = 1; k <= 4; k++) begin
          int j;
          j = (m_last + k) % 4;
          if (req[j]) begin
            m_owner = j;
            m_len   = int'(len[j*8 +: 8]);
            m_age   = 0;
            break;
          end
        end
    end else if ((m_age <= m_len && !req[m_owner]) || m_age == m_len + 1) begin
      m_last  = m_owner;
      m_owner = -1;
    end else m_age++;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_age   = 0;
    m_len   = 0;
  endtask

  task automatic step(input string tag, input logic [3:0] r, input logic [31:0] l);
    req = r;
    len = l;
    model_tick();
    @(posedge clk);
    #1;
    if (done[2]) seen_done = 1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    req = '0;
    rst = 1;
    model_reset();
    #1;
    check_all(tag);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    seen_done = 0;
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 8; i++) step("t1", 4'b0001, 32'h0000_0003);
    do_reset("t2.rst");
    for (int i = 0; i < 12; i++) step("t2", 4'b0110, 32'h0001_0200);
    do_reset("t3.rst");
    for (int i = 0; i < 16; i++) step("t3", 4'b1111, 32'h0000_0000);
    do_reset("t4.rst");
    step("t4", 4'b0001, 32'h0000_000A);
    for (int i = 0; i < 20 && !(m_owner == 0 && m_age == 4); i++) step("t4", 4'b0001, 32'h0000_000A);
    check("t4.count_at_drop", 32'(count), 32'd4);
    step("t4.drop", 4'b0000, 32'h0000_000A);
    step("t4.idle", 4'b0000, 32'h0000_000A);
    step("t4.rr", 4'b0011, 32'h0000_0202);
    check("t4.rr_gnt", 32'(gnt), 32'd2);
    for (int i = 0; i < 12; i++) step("t4", 4'b0011, 32'h0000_0202);
    do_reset("t5.rst");
    for (int i = 0; i < 80 && !(m_owner == 2 && m_age == 50); i++) step("t5", 4'b0100, 32'h00C8_0000);
    check("t5.count_at_rst", 32'(count), 32'd50);
    #2;
    rst = 1;
    model_reset();
    #1;
    check_all("t5.async");
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    seen_done = 0;
    step("t5.restart", 4'b0100, 32'h00C8_0000);
    for (int i = 0; i < 260 && !seen_done; i++) step("t5", 4'b0100, 32'h00C8_0000);
    check("t5.done_seen", 32'(seen_done), 32'd1);
    do_reset("t6.rst");
    step("t6", 4'b0001, 32'h0000_0003);
    for (int i = 0; i < 8; i++) step("t6", 4'b0001, 32'h0000_0009);
    begin
      logic [3:0]  r;
      logic [31:0] l;
      r = 4'b1111;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 5) == 0) r = 4'($urandom_range(0, 15));
        for (int b = 0; b < 4; b++) l[b*8 +: 8] = 8'($urandom_range(0, 5));
        step("rand", r, l);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
